// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and defaults for the stack access unit
package stack_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PUSH_MEM = 2'd1,
    POP_MEM  = 2'd2
  } stack_state_t;

  localparam logic [31:0] STACK_BASE_DEFAULT  = 32'd256;
  localparam logic [31:0] STACK_DEPTH_DEFAULT = 32'd256;

endpackage

// File: rtl/stack_access_unit.sv
// rtl/stack_access_unit.sv - PUSH/POP sequencing engine with one memory access per operation
module stack_access_unit
  import stack_pkg::*;
#(
  parameter logic [31:0] STACK_BASE  = STACK_BASE_DEFAULT,
  parameter logic [31:0] STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic        op_push,
  input  logic [31:0] push_data,
  output logic        op_ready,
  input  logic [31:0] sp_top,
  output logic [31:0] sp_new_top,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        pop_valid,
  output logic [31:0] pop_data,
  output logic        err_overflow,
  output logic        err_underflow,
  output logic [31:0] stack_count
);

  localparam logic [31:0] FULL_TOP = STACK_BASE + STACK_DEPTH;

  stack_state_t state;
  logic         is_full;
  logic         is_empty;

  assign is_full     = (sp_top == FULL_TOP);
  assign is_empty    = (sp_top == STACK_BASE);
  assign stack_count = sp_top - STACK_BASE;

  // The SP register reloads every cycle, so pass sp_top through unless committing.
  always_comb begin
    sp_new_top = sp_top;
    if (mem_ack) begin
      if (state == PUSH_MEM)
        sp_new_top = sp_top + 32'd1;
      else if (state == POP_MEM)
        sp_new_top = sp_top - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_ready      <= 1'b1;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wdata     <= 32'd0;
      pop_valid     <= 1'b0;
      pop_data      <= 32'd0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      pop_valid     <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            if (op_push) begin
              if (is_full) begin
                err_overflow <= 1'b1;
              end else begin
                state     <= PUSH_MEM;
                op_ready  <= 1'b0;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= sp_top;
                mem_wdata <= push_data;
              end
            end else begin
              if (is_empty) begin
                err_underflow <= 1'b1;
              end else begin
                state    <= POP_MEM;
                op_ready <= 1'b0;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= sp_top - 32'd1;
              end
            end
          end
        end
        PUSH_MEM: begin
          if (mem_ack) begin
            state    <= IDLE;
            op_ready <= 1'b1;
            mem_req  <= 1'b0;
          end
        end
        POP_MEM: begin
          if (mem_ack) begin
            state     <= IDLE;
            op_ready  <= 1'b1;
            mem_req   <= 1'b0;
            pop_data  <= mem_rdata;
            pop_valid <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          op_ready <= 1'b1;
          mem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_access_unit.sv
// tb/tb_stack_access_unit.sv - scoreboard bench for stack_access_unit
module tb_stack_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, op_push;
  logic [31:0] push_data;
  logic        op_ready;
  logic [31:0] sp_top, sp_new_top;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        pop_valid;
  logic [31:0] pop_data;
  logic        err_overflow, err_underflow;
  logic [31:0] stack_count;

  logic        sp_load;
  logic [31:0] sp_load_val;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] exp_pop_q[$];
  logic [31:0] model_stack[$];
  logic [31:0] mem_model [logic [31:0]];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Stand-in for the core's stack pointer register (no reset, reloads every edge).
  always @(posedge clk) sp_top <= sp_load ? sp_load_val : sp_new_top;

  stack_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_push(op_push), .push_data(push_data), .op_ready(op_ready),
    .sp_top(sp_top), .sp_new_top(sp_new_top),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pop_valid(pop_valid), .pop_data(pop_data),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .stack_count(stack_count)
  );

  task automatic load_sp(input logic [31:0] v);
    sp_load = 1'b1; sp_load_val = v;
    @(negedge clk);
    sp_load = 1'b0;
  endtask

  // Drives one valid operation starting at a negedge with op_ready high; ack arrives
  // after 'delay' extra request cycles. Ends at the negedge of A+1.
  task automatic do_op(input string nm, input bit push, input logic [31:0] data, input int delay);
    acc_t        e;
    logic [31:0] sp0, exp_sp, ep, a0, w0;
    sp0 = sp_top;
    exp_sp = push ? sp0 + 32'd1 : sp0 - 32'd1;
    n_tests++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL %s op_ready_before: got %b want 1", nm, op_ready); end
    op_valid = 1'b1; op_push = push; push_data = data;
    exp_q.push_back('{we: push, addr: (push ? sp0 : sp0 - 32'd1), wdata: (push ? data : 32'd0)});
    if (push) model_stack.push_back(data);
    else begin exp_pop_q.push_back(model_stack[$]); void'(model_stack.pop_back()); end
    @(negedge clk);
    op_valid = 1'b0; push_data = $urandom;
    a0 = mem_addr; w0 = mem_wdata;
    for (int c = 0; c <= delay; c++) begin
      if (c == delay) begin
        mem_ack = 1'b1;
        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'hDEAD_BEEF;
      end
      #1;
      n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL %s mem_req c%0d: got %b want 1", nm, c, mem_req); end
      n_tests++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL %s op_ready_busy c%0d: got %b want 0", nm, c, op_ready); end
      n_tests++; if (mem_addr !== a0 || (push && mem_wdata !== w0)) begin n_fail++; $display("FAIL %s stable c%0d: got %h/%h want %h/%h", nm, c, mem_addr, mem_wdata, a0, w0); end
      n_tests++; if (sp_new_top !== ((c == delay) ? exp_sp : sp0)) begin n_fail++; $display("FAIL %s sp_new_top c%0d: got %h want %h", nm, c, sp_new_top, (c == delay) ? exp_sp : sp0); end
      if (c == delay) begin
        e = exp_q.pop_front();
        n_tests++; if (mem_we !== e.we || mem_addr !== e.addr) begin n_fail++; $display("FAIL %s access: got we=%b addr=%h want we=%b addr=%h", nm, mem_we, mem_addr, e.we, e.addr); end
        if (push) begin
          n_tests++; if (mem_wdata !== e.wdata) begin n_fail++; $display("FAIL %s wdata: got %h want %h", nm, mem_wdata, e.wdata); end
          mem_model[mem_addr] = mem_wdata;
        end
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    n_tests++; if (op_ready !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL %s after_ack: got ready=%b req=%b want 1/0", nm, op_ready, mem_req); end
    n_tests++; if (sp_top !== exp_sp) begin n_fail++; $display("FAIL %s sp_after: got %h want %h", nm, sp_top, exp_sp); end
    n_tests++; if (pop_valid !== !push || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin n_fail++; $display("FAIL %s pulses: got pv=%b ov=%b un=%b want pv=%b", nm, pop_valid, err_overflow, err_underflow, !push); end
    if (!push) begin
      ep = exp_pop_q.pop_front();
      n_tests++; if (pop_data !== ep) begin n_fail++; $display("FAIL %s pop_data: got %h want %h", nm, pop_data, ep); end
    end
  endtask

  task automatic do_reject(input string nm, input bit push);
    logic [31:0] sp0;
    sp0 = sp_top;
    op_valid = 1'b1; op_push = push; push_data = 32'h1234_5678;
    @(negedge clk);
    op_valid = 1'b0;
    n_tests++; if (err_overflow !== push || err_underflow !== !push) begin n_fail++; $display("FAIL %s err_pulse: got ov=%b un=%b want ov=%b un=%b", nm, err_overflow, err_underflow, push, !push); end
    n_tests++; if (mem_req !== 1'b0 || op_ready !== 1'b1 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL %s no_access: got req=%b ready=%b pv=%b want 0/1/0", nm, mem_req, op_ready, pop_valid); end
    @(negedge clk);
    n_tests++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL %s err_clear: got ov=%b un=%b req=%b want 0", nm, err_overflow, err_underflow, mem_req); end
    n_tests++; if (sp_top !== sp0) begin n_fail++; $display("FAIL %s sp_hold: got %h want %h", nm, sp_top, sp0); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; op_valid = 1'b0; op_push = 1'b0; push_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    sp_load = 1'b1; sp_load_val = 32'd256;
    repeat (3) @(negedge clk);
    sp_load = 1'b0;
    n_tests++; if (op_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset ctrl: got ready=%b req=%b we=%b want 1/0/0", op_ready, mem_req, mem_we); end
    n_tests++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || pop_data !== 32'd0) begin n_fail++; $display("FAIL reset data: got %h %h %h want 0", mem_addr, mem_wdata, pop_data); end
    n_tests++; if (pop_valid !== 1'b0 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset pulses: got %b%b%b want 000", pop_valid, err_overflow, err_underflow); end
    n_tests++; if (sp_new_top !== 32'd256 || stack_count !== 32'd0) begin n_fail++; $display("FAIL reset sp: got new=%h cnt=%h want 100/0", sp_new_top, stack_count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_push_pop;
    do_op("push_basic", 1'b1, 32'hA5A5_0001, 1);
    n_tests++; if (stack_count !== 32'd1) begin n_fail++; $display("FAIL push_basic count: got %0d want 1", stack_count); end
    do_op("pop_basic", 1'b0, 32'h0, 1);
    n_tests++; if (sp_top !== 32'd256 || stack_count !== 32'd0) begin n_fail++; $display("FAIL pop_basic sp: got %h cnt=%0d want 100/0", sp_top, stack_count); end
  endtask

  task automatic test_underflow;
    do_reject("underflow", 1'b0);
  endtask

  task automatic test_overflow;
    load_sp(32'd512);
    do_reject("overflow", 1'b1);
    load_sp(32'd511);
    model_stack.delete();
    do_op("push_last_slot", 1'b1, 32'h0BAD_F00D, 0);
    do_reject("overflow_after_fill", 1'b1);
    do_op("pop_last_slot", 1'b0, 32'h0, 2);
    load_sp(32'd256);
    model_stack.delete();
  endtask

  task automatic test_slow_ack;
    do_op("push_slow", 1'b1, 32'hC0DE_0003, 3);
    do_op("pop_slow", 1'b0, 32'h0, 3);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) do_op("b2b_push", 1'b1, 32'h1000_0000 + $urandom_range(0, 65535), 0);
    for (int i = 0; i < 4; i++) do_op("b2b_pop", 1'b0, 32'h0, i % 2);
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] sp0, pd0;
    do_op("rst_setup", 1'b1, 32'h7777_0007, 0);
    sp0 = sp_top; pd0 = pop_data;
    op_valid = 1'b1; op_push = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid req_before: got %b want 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b0 || op_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid async: got req=%b ready=%b want 0/1", mem_req, op_ready); end
    n_tests++; if (sp_new_top !== sp0) begin n_fail++; $display("FAIL rst_mid sp_new_top: got %h want %h", sp_new_top, sp0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (pop_valid !== 1'b0 || sp_top !== sp0 || op_ready !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid after: got pv=%b sp=%h ready=%b req=%b want 0/%h/1/0", pop_valid, sp_top, op_ready, mem_req, sp0); end
    do_op("pop_after_rst", 1'b0, 32'h0, 1);
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_underflow();
    test_overflow();
    test_slow_ack();
    test_back_to_back();
    test_reset_mid_access();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
